// File: rtl/mips16_muldiv_pkg.sv
// Shared constants and types for the mips16 multiply/divide unit.
// Divider datapath is compiled in only when MIPS16_MULDIV_DIV_EN is defined.
package mips16_muldiv_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_DIVU  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mips16_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module mips16_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff  = {rem_i, bit_i} - {1'b0, div_i};
        q_o   = ~diff[WIDTH];
        rem_o = q_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};
    end

endmodule

// File: rtl/mips16_muldiv.sv
// Iterative 16-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MIPS16_MULDIV_DIV_EN to build the divider; otherwise divides flag div_zero.
module mips16_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_lo_sl,
    output logic [WIDTH-1:0] out,
    output logic             instr_stall_sl,
    output logic             ready,
    output logic             div_zero
);

    import mips16_muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               op_div, op_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MIPS16_MULDIV_DIV_EN
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // acc holds {partial remainder, dividend bits not yet consumed / quotient}
    mips16_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .bit_i (acc_q[WIDTH-1]),
        .div_i (opnd_q),
        .rem_o (div_rem),
        .q_o   (div_qbit)
    );

    always_comb begin
        div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
`endif

    always_comb begin
        op_div = 1'b0;
        op_sgn = 1'b0;
        unique case (op)
            OP_MULTU: ;
            OP_MULT:  op_sgn = 1'b1;
            OP_DIVU:  op_div = 1'b1;
            OP_DIV: begin
                op_div = 1'b1;
                op_sgn = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_mag = (op_sgn && a[WIDTH-1]) ? -a : a;
        b_mag = (op_sgn && b[WIDTH-1]) ? -b : b;
    end

    // Shift-add: acc = {partial product, unconsumed multiplier bits}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        is_div_d       = is_div_q;
        sa_d           = sa_q;
        sb_d           = sb_q;
        opnd_d         = opnd_q;
        acc_d          = acc_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        div_zero_d     = div_zero_q;
`ifdef MIPS16_MULDIV_DIV_EN
        dz_d           = dz_q;
        araw_d         = araw_q;
`endif
        instr_stall_sl = 1'b0;
        ready          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    instr_stall_sl = 1'b1;
                    is_div_d       = op_div;
                    sa_d           = op_sgn & a[WIDTH-1];
                    sb_d           = op_sgn & b[WIDTH-1];
                    opnd_d         = op_div ? b_mag : a_mag;
                    acc_d          = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    cnt_d          = '0;
                    div_zero_d     = 1'b0;
                    state_d        = ST_RUN;
`ifdef MIPS16_MULDIV_DIV_EN
                    dz_d           = (b == '0);
                    araw_d         = a;
`else
                    if (op_div) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                instr_stall_sl = 1'b1;
`ifdef MIPS16_MULDIV_DIV_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
`ifdef MIPS16_MULDIV_DIV_EN
                    if (dz_q) begin
                        hi_d       = araw_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
`else
                    div_zero_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
`ifdef MIPS16_MULDIV_DIV_EN
            dz_q       <= 1'b0;
            araw_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
`ifdef MIPS16_MULDIV_DIV_EN
            dz_q       <= dz_d;
            araw_q     <= araw_d;
`endif
        end
    end

    assign out      = hi_lo_sl ? hi_q : lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/mips16_muldiv.md
# mips16_muldiv

Iterative 16-bit multiply/divide unit with architectural HI/LO registers for the mips16 single-cycle core. It sits downstream of the core's register-file read ports, in parallel with the ALU. It consumes both source operands when a MULT/MULTU/DIV/DIVU instruction is decoded and holds the core with `instr_stall_sl` until the 32-bit result is written into HI/LO. The core's MFHI/MFLO path reads the result through `out`, selected by `hi_lo_sl`.

## Interface
Parameters
- `WIDTH`, 16, operand width; HI and LO are each `WIDTH` bits.

Ports
- `clock`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  decoder request; sampled only in IDLE.
- `op`  in  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- `a`  in  WIDTH  rs data (multiplicand or dividend).
- `b`  in  WIDTH  rt data (multiplier or divisor).
- `hi_lo_sl`  in  1  output select: 1 = HI, 0 = LO.
- `out`  out  WIDTH  HI or LO, combinational from the registers.
- `instr_stall_sl`  out  1  stall request to the PC/instruction path.
- `ready`  out  1  one-cycle pulse when HI/LO have been updated.
- `div_zero`  out  1  sticky; set by a divide with `b`=0 and cleared by the next `start`.

Reset values: HI=0, LO=0, `ready`=0, `div_zero`=0, state IDLE, `instr_stall_sl`=0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + `start`: latch `op`, `a` and `b`.
  - Signed ops latch operand magnitudes plus the sign bits.
  - Clear `div_zero`; counter=0; go to RUN.
- RUN: one iteration per cycle for exactly `WIDTH` cycles; counter 0..15, then go to DONE.
  - Multiply: shift-add of a 32-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
- DONE: apply sign correction and write HI/LO.
  - Pulse `ready`; go to IDLE.
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder.
- Signed sign correction:
  - Product sign and quotient sign = sa^sb.
  - Remainder sign = sa.
  - All arithmetic is truncated to 32/16 bits, no saturation; DIV −32768/−1 gives LO=0x8000, HI=0.
- Divide by zero: latched at start and still runs the full 16 cycles.
  - Result HI=`a` as sampled, LO=0xFFFF.
  - `div_zero`=1.
- `start` in RUN or DONE is ignored; there is no queueing.
- HI/LO keep their previous values until DONE. `out` reads the old values during RUN.

## Timing
- `start` sampled high in IDLE at edge N:
  - RUN spans cycles N+1..N+16.
  - DONE is cycle N+17; HI/LO are valid from edge N+17 onward.
- `instr_stall_sl` is combinational: `(IDLE & start) | RUN`. The core stalls in the same cycle the instruction is decoded and is released in DONE, so the next instruction issues at N+17.
- `ready` is high only during DONE.
- Back-to-back ops: a `start` in the cycle after DONE is accepted normally. Minimum issue interval is 18 cycles.
- `reset` at any edge: return to IDLE and zero HI/LO. No `ready` pulse is produced for the aborted op.

## Configuration
- `MIPS16_MULDIV_DIV_EN` defined: divider datapath compiled in; behaviour as above.
- Undefined: DIV/DIVU take IDLE→DONE directly with no RUN cycles.
  - HI/LO are unchanged.
  - `ready` pulses and `div_zero` is set, flagging an unsupported op.
  - Multiply behaviour is identical in both builds.

## Structure
- Package `mips16_muldiv_pkg` holds:
  - op encodings (`OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`);
  - the state enum;
  - the iteration count constant (`WIDTH`).
- Sub-module `mips16_div_step`: combinational single restoring-divide iteration (partial remainder and divisor in; next remainder and quotient bit out). It is instantiated only under `MIPS16_MULDIV_DIV_EN`.
- Top holds the FSM, counter, accumulators, sign fix-up and HI/LO.

## Test plan
- MULTU a=300, b=500 → after 17 cycles of stall, HI=0x0002, LO=0x49F0, `ready` pulse at N+17.
- MULT a=0xFFFD (−3), b=7 → HI=0xFFFF, LO=0xFFEB. Check `out` with `hi_lo_sl` toggled, and that old HI/LO are held during RUN.
- DIVU a=100, b=7 → LO=14, HI=2. DIV a=0xFFF9 (−7), b=2 → LO=0xFFFD, HI=0xFFFF. DIV 0x8000 / 0xFFFF → LO=0x8000, HI=0.
- DIVU a=0x1234, b=0 → HI=0x1234, LO=0xFFFF, `div_zero`=1. The next `start` clears `div_zero`.
- `start` pulsed during RUN is ignored. `reset` at RUN cycle 8 → IDLE, HI=LO=0, no `ready`, stall drops the next cycle.
- Build without `MIPS16_MULDIV_DIV_EN`: DIVU → `ready` at N+1, HI/LO unchanged, `div_zero`=1. MULTU is unchanged.
